instr_fetch_decode: RTL and testbench

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode.sv | 181 ++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode stage: byte-wide program memory, 16-entry jump-label
// table, IDLE/RUN/HALT sequencer and a registered decode slot with valid/ready handshake.
module instr_fetch_decode #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  input  logic            lbl_we,
  input  logic [3:0]      lbl_addr,
  input  logic [PC_W-1:0] lbl_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [1:0]      format,
  output logic [3:0]      opcode,
  output logic [2:0]      reg1_i,
  output logic [2:0]      reg2_i,
  output logic [2:0]      reg_o,
  output logic [2:0]      imm,
  output logic            imm_flag,
  output logic [PC_W-1:0] jmp_loc,
  output logic            halted,
  output logic            busy
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0] DEPTH_W = (PC_W + 1)'(DEPTH);
  localparam logic [7:0]    HALT_INSTR = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  typedef enum logic [1:0] {FMT_C = 2'b00, FMT_I = 2'b01, FMT_M = 2'b10, FMT_X = 2'b11} fmt_t;

  // NOTE: storage arrays are deliberately left out of reset; a reset must not wipe the
  // loaded program or labels, and unreset arrays map cleanly onto RAM primitives.
  logic [7:0]      mem    [DEPTH] = '{default: HALT_INSTR};
  logic [PC_W-1:0] labels [16]    = '{default: '0};

  state_t          state;
  logic [PC_W-1:0] pc;

  logic            pc_in_range;
  logic            prog_in_range;
  logic [7:0]      instr;
  logic [3:0]      d_op;
  fmt_t            d_fmt;
  logic [2:0]      d_r1;
  logic [2:0]      d_r2;
  logic [2:0]      d_ro;
  logic [2:0]      d_imm;
  logic            d_imm_flag;
  logic [PC_W-1:0] d_jmp;
  logic            fetch;

  assign pc_in_range   = ({1'b0, pc} < DEPTH_W);
  assign prog_in_range = ({1'b0, prog_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (!reset && prog_we && (state != S_RUN) && prog_in_range)
      mem[prog_addr[AW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && lbl_we)
      labels[lbl_addr] <= lbl_data;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    instr      = pc_in_range ? mem[pc[AW-1:0]] : HALT_INSTR;
    d_op       = instr[7:4];
    d_fmt      = FMT_M;
    d_r1       = 3'd0;
    d_r2       = 3'd0;
    d_ro       = 3'd0;
    d_imm      = instr[3:1];
    d_imm_flag = instr[0];
    d_jmp      = '0;

    case (d_op)
      4'b0010, 4'b0100: d_fmt = FMT_C;
      4'b1001, 4'b1101: d_fmt = FMT_I;
      4'b1110:          d_fmt = FMT_X;
      default:          d_fmt = FMT_M;
    endcase

    case (d_fmt)
      FMT_C: begin
        d_ro  = instr[0] ? 3'd3 : 3'd2;
        d_jmp = labels[instr[3:0]];
      end
      FMT_I: begin
        d_r1 = instr[3:1];
        d_r2 = instr[3:1] + 3'd1;
        d_ro = instr[3:1];
      end
      FMT_M: begin
        // MVB moves high bank into low bank, the reverse of every other M-type op.
        if (d_op == 4'b0101) begin
          d_r1 = {1'b1, instr[1:0]};
          d_ro = {1'b0, instr[3:2]};
        end else begin
          d_r1 = {1'b0, instr[3:2]};
          d_r2 = {1'b0, instr[3:2]} + 3'd1;
          d_ro = {1'b1, instr[1:0]};
        end
        d_jmp = labels[{2'b11, instr[1:0]}];
      end
      default: begin
        d_imm      = 3'd0;
        d_imm_flag = 1'b0;
      end
    endcase
  end

  assign fetch = (!out_valid || out_ready) && !redirect_valid;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      format    <= 2'b00;
      opcode    <= 4'd0;
      reg1_i    <= 3'd0;
      reg2_i    <= 3'd0;
      reg_o     <= 3'd0;
      imm       <= 3'd0;
      imm_flag  <= 1'b0;
      jmp_loc   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end else if (fetch) begin
            pc        <= pc + PC_W'(1);
            out_valid <= 1'b1;
            out_pc    <= pc;
            format    <= d_fmt;
            opcode    <= d_op;
            reg1_i    <= d_r1;
            reg2_i    <= d_r2;
            reg_o     <= d_ro;
            imm       <= d_imm;
            imm_flag  <= d_imm_flag;
            jmp_loc   <= d_jmp;
            if (d_fmt == FMT_X)
              state <= S_HALT;
          end
        end
        S_IDLE, S_HALT: begin
          if (start) begin
            state     <= S_RUN;
            pc        <= '0;
            out_valid <= 1'b0;
          end else if (out_valid && out_ready) begin
            // The HALT instruction stays presented until the consumer takes it.
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: expected decodes are queued from a bench-side
// program/label model and compared whenever the DUT hands over an instruction.
module tb_instr_fetch_decode;

  localparam int PC_W  = 16;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  fmt;
    logic [3:0]  op;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [2:0]  ro;
    logic [2:0]  imm;
    logic        immf;
    logic [15:0] jmp;
  } dec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            prog_we;
  logic [PC_W-1:0] prog_addr;
  logic [7:0]      prog_data;
  logic            lbl_we;
  logic [3:0]      lbl_addr;
  logic [PC_W-1:0] lbl_data;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            out_ready;
  logic            out_valid;
  logic [PC_W-1:0] out_pc;
  logic [1:0]      format;
  logic [3:0]      opcode;
  logic [2:0]      reg1_i;
  logic [2:0]      reg2_i;
  logic [2:0]      reg_o;
  logic [2:0]      imm;
  logic            imm_flag;
  logic [PC_W-1:0] jmp_loc;
  logic            halted;
  logic            busy;

  int   n_vec  = 0;
  int   n_miss = 0;
  dec_t sb[$];
  dec_t exp_d;

  logic [7:0]  bmem [DEPTH];
  logic [15:0] blbl [16];

  instr_fetch_decode #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .lbl_we        (lbl_we),
    .lbl_addr      (lbl_addr),
    .lbl_data      (lbl_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .format        (format),
    .opcode        (opcode),
    .reg1_i        (reg1_i),
    .reg2_i        (reg2_i),
    .reg_o         (reg_o),
    .imm           (imm),
    .imm_flag      (imm_flag),
    .jmp_loc       (jmp_loc),
    .halted        (halted),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decoder written straight from the instruction-set table.
  function automatic dec_t model(input logic [15:0] pc_v);
    logic [7:0] ins;
    logic [3:0] op;
    dec_t d;
    ins    = (pc_v < 16'd32) ? bmem[pc_v[4:0]] : 8'hE0;
    op     = ins[7:4];
    d      = '0;
    d.pc   = pc_v;
    d.op   = op;
    d.imm  = ins[3:1];
    d.immf = ins[0];
    if (op == 4'he) begin
      d.fmt  = 2'b11;
      d.imm  = 3'd0;
      d.immf = 1'b0;
    end else if (op == 4'h2 || op == 4'h4) begin
      d.fmt = 2'b00;
      d.ro  = (ins[0] == 1'b1) ? 3'd3 : 3'd2;
      d.jmp = blbl[ins[3:0]];
    end else if (op == 4'h9 || op == 4'hd) begin
      d.fmt = 2'b01;
      d.r1  = ins[3:1];
      d.r2  = 3'(ins[3:1] + 3'd1);
      d.ro  = ins[3:1];
    end else begin
      d.fmt = 2'b10;
      d.jmp = blbl[{2'b11, ins[1:0]}];
      if (op == 4'h5) begin
        d.r1 = {1'b1, ins[1:0]};
        d.ro = {1'b0, ins[3:2]};
      end else begin
        d.r1 = {1'b0, ins[3:2]};
        d.r2 = {1'b0, ins[3:2]} + 3'd1;
        d.ro = {1'b1, ins[1:0]};
      end
    end
    return d;
  endfunction

  // Non-halting filler program touching every format.
  function automatic logic [7:0] fill_val(input int i);
    logic [3:0] op;
    op = 4'((i * 5 + 3) % 16);
    if (op == 4'he) op = 4'hf;
    return {op, 4'((i * 3 + 1) % 16)};
  endfunction

  // Every handshake transfer pops the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !(busy && redirect_valid)) begin
      if (sb.size() == 0) begin
        check("sb_pop", sb.size(), 1);
      end else begin
        exp_d = sb.pop_front();
        check("out_pc",   32'(out_pc),   32'(exp_d.pc));
        check("format",   32'(format),   32'(exp_d.fmt));
        check("opcode",   32'(opcode),   32'(exp_d.op));
        check("reg1_i",   32'(reg1_i),   32'(exp_d.r1));
        check("reg2_i",   32'(reg2_i),   32'(exp_d.r2));
        check("reg_o",    32'(reg_o),    32'(exp_d.ro));
        check("imm",      32'(imm),      32'(exp_d.imm));
        check("imm_flag", 32'(imm_flag), 32'(exp_d.immf));
        check("jmp_loc",  32'(jmp_loc),  32'(exp_d.jmp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [15:0] a, input logic [7:0] d, input bit effective);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
    if (effective) bmem[a[4:0]] = d;
  endtask

  task automatic label_write(input logic [3:0] a, input logic [15:0] d);
    lbl_we   = 1'b1;
    lbl_addr = a;
    lbl_data = d;
    tick();
    lbl_we  = 1'b0;
    blbl[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    for (int p = first; p <= last; p++) sb.push_back(model(16'(p)));
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted && !out_valid) break;
      tick();
    end
    @(negedge clk);
    check("halt_state", {30'd0, halted, out_valid}, 32'b10);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) bmem[i] = 8'hE0;
    for (int i = 0; i < 16; i++) blbl[i] = 16'd0;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    lbl_we = 1'b0; lbl_addr = '0; lbl_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid",  32'(out_valid), 0);
    check("rst_busy",   32'(busy),      0);
    check("rst_halted", 32'(halted),    0);
    check("rst_pc",     32'(out_pc),    0);
    check("rst_format", 32'(format),    0);
    check("rst_jmp",    32'(jmp_loc),   0);
    reset = 1'b0;
    tick();

    // Two-instruction program ending in HALT, with first-fetch latency.
    prog_write(16'd0, 8'h4E, 1'b1);
    prog_write(16'd1, 8'hE0, 1'b1);
    push_range(0, 1);
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    check("lat_busy",   32'(busy),      1);
    check("lat_valid0", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    check("lat_valid1", 32'(out_valid), 1);
    check("lat_pc",     32'(out_pc),    0);
    wait_halt(20);

    // Label resolution for an M-type branch.
    for (int k = 0; k < 16; k++) label_write(4'(k), (k == 13) ? 16'd40 : 16'(100 + 7 * k));
    prog_write(16'd0, 8'hB1, 1'b1);
    push_range(0, 1);
    tick();
    pulse_start();
    wait_halt(20);
    check("lbl13_model", 32'(blbl[13]), 40);

    // Redirect from pc=5 to 20, then run off the end of memory into HALT.
    for (int i = 0; i < DEPTH; i++) prog_write(16'(i), fill_val(i), 1'b1);
    push_range(0, 3);
    push_range(20, 32);
    tick();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_pc == 16'd4) break;
      tick();
    end
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'd20;
    check("redir_at", 32'(out_pc), 4);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    check("redir_flush", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    check("redir_valid", 32'(out_valid), 1);
    check("redir_pc",    32'(out_pc),    20);
    wait_halt(100);

    // Stall at out_pc=3; prog_we and start during RUN must be ignored.
    push_range(0, 32);
    tick();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_pc == 16'd3) break;
      tick();
    end
    out_ready = 1'b0;
    check("stall_entry", 32'(out_pc), 3);
    prog_write(16'd5, 8'hE0, 1'b0);
    @(negedge clk);
    check("stall_pc1", 32'(out_pc), 3);
    check("stall_v1",  32'(out_valid), 1);
    pulse_start();
    @(negedge clk);
    check("stall_pc2", 32'(out_pc), 3);
    check("stall_v2",  32'(out_valid), 1);
    tick();
    @(negedge clk);
    check("stall_pc3", 32'(out_pc), 3);
    check("stall_v3",  32'(out_valid), 1);
    out_ready = 1'b1;
    wait_halt(100);

    // Reset mid-RUN discards the presented instruction but keeps the program.
    out_ready = 1'b0;
    tick();
    pulse_start();
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_valid",  32'(out_valid), 0);
    check("mid_rst_busy",   32'(busy),      0);
    check("mid_rst_halted", 32'(halted),    0);
    check("mid_rst_pc",     32'(out_pc),    0);
    check("mid_rst_format", 32'(format),    0);
    check("mid_rst_opcode", 32'(opcode),    0);
    check("mid_rst_reg_o",  32'(reg_o),     0);
    check("mid_rst_jmp",    32'(jmp_loc),   0);
    reset = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'd9;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("idle_redir_busy",  32'(busy),      0);
    check("idle_redir_valid", 32'(out_valid), 0);
    push_range(0, 32);
    out_ready = 1'b1;
    tick();
    pulse_start();
    wait_halt(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
